// File: rtl/alu_exec_if.sv
// Operation/result bundle between the issuing stage and the execute-stage ALU.
// The master drives operations; the slave (alu_exec) returns results.
interface alu_exec_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alucontrol;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  sa;
   logic        out_valid;
   logic [31:0] result;
   logic        overflow;
   logic        hilo_we;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output flush, in_valid, alucontrol, a, b, sa,
      input  in_ready, out_valid, result, overflow, hilo_we, hi, lo
   );

   modport slave (
      input  flush, in_valid, alucontrol, a, b, sa,
      output in_ready, out_valid, result, overflow, hilo_we, hi, lo
   );
endinterface

// File: rtl/alu_exec.sv
// MIPS execute-stage ALU: single-cycle ops with one-cycle registered latency,
// plus a one-cycle multiplier and a 32-iteration restoring divider writing HI/LO.
module alu_exec (
   input logic       clk,
   input logic       resetn,
   alu_exec_if.slave bus
);

   localparam logic [4:0] OpAnd   = 5'b00001;
   localparam logic [4:0] OpOr    = 5'b00010;
   localparam logic [4:0] OpXor   = 5'b00011;
   localparam logic [4:0] OpNor   = 5'b00100;
   localparam logic [4:0] OpAdd   = 5'b00101;
   localparam logic [4:0] OpAddu  = 5'b00110;
   localparam logic [4:0] OpSub   = 5'b00111;
   localparam logic [4:0] OpSubu  = 5'b01000;
   localparam logic [4:0] OpSlt   = 5'b01001;
   localparam logic [4:0] OpSltu  = 5'b01010;
   localparam logic [4:0] OpSll   = 5'b01011;
   localparam logic [4:0] OpLui   = 5'b01100;
   localparam logic [4:0] OpMult  = 5'b01101;
   localparam logic [4:0] OpMultu = 5'b01110;
   localparam logic [4:0] OpDiv   = 5'b01111;
   localparam logic [4:0] OpDivu  = 5'b10000;

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] opa_q, opa_d;     // multiplicand, or dividend shifting into quotient
   logic [31:0] opb_q, opb_d;     // multiplier, or divisor magnitude
   logic [31:0] rem_q, rem_d;
   logic [31:0] orig_q, orig_d;   // raw dividend, returned in HI on divide by zero
   logic        sgn_q, sgn_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dbz_q, dbz_d;
   logic        out_valid_q, out_valid_d;
   logic        overflow_q, overflow_d;
   logic        hilo_we_q, hilo_we_d;
   logic [31:0] result_q, result_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] sum, dif, alu_res;
   logic        alu_ovf;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] rem_step, quo_step;
   logic [63:0] mul_a, mul_b, prod;
   logic        is_mul, is_div, div_sgn;

   assign sum = bus.a + bus.b;
   assign dif = bus.a - bus.b;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.alucontrol)
         OpAnd:  alu_res = bus.a & bus.b;
         OpOr:   alu_res = bus.a | bus.b;
         OpXor:  alu_res = bus.a ^ bus.b;
         OpNor:  alu_res = ~(bus.a | bus.b);
         OpAdd: begin
            alu_res = sum;
            alu_ovf = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
         end
         OpAddu: alu_res = sum;
         OpSub: begin
            alu_res = dif;
            alu_ovf = (bus.a[31] != bus.b[31]) && (dif[31] != bus.a[31]);
         end
         OpSubu: alu_res = dif;
         OpSlt:  alu_res = {31'b0, $signed(bus.a) < $signed(bus.b)};
         OpSltu: alu_res = {31'b0, bus.a < bus.b};
         OpSll:  alu_res = bus.b << bus.sa;
         OpLui:  alu_res = {bus.b[15:0], 16'h0};
         default: ;
      endcase
   end

   // One restoring step on magnitudes: shift in next dividend bit, subtract if it fits.
   assign div_shift = {rem_q, opa_q[31]};
   assign div_ge    = div_shift >= {1'b0, opb_q};
   assign rem_step  = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
   assign quo_step  = {opa_q[30:0], div_ge};

   assign mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
   assign mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
   assign prod  = mul_a * mul_b;

   assign is_mul  = (bus.alucontrol == OpMult) || (bus.alucontrol == OpMultu);
   assign is_div  = (bus.alucontrol == OpDiv) || (bus.alucontrol == OpDivu);
   assign div_sgn = (bus.alucontrol == OpDiv);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      rem_d       = rem_q;
      orig_d      = orig_q;
      sgn_d       = sgn_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      dbz_d       = dbz_q;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
      hilo_we_d   = 1'b0;
      result_d    = result_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               if (is_mul) begin
                  state_d = StMul;
                  opa_d   = bus.a;
                  opb_d   = bus.b;
                  sgn_d   = (bus.alucontrol == OpMult);
               end else if (is_div) begin
                  state_d = StDiv;
                  cnt_d   = '0;
                  opa_d   = (div_sgn && bus.a[31]) ? -bus.a : bus.a;
                  opb_d   = (div_sgn && bus.b[31]) ? -bus.b : bus.b;
                  rem_d   = '0;
                  orig_d  = bus.a;
                  qneg_d  = div_sgn && (bus.a[31] ^ bus.b[31]);
                  rneg_d  = div_sgn && bus.a[31];
                  dbz_d   = (bus.b == '0);
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  overflow_d  = alu_ovf;
               end
            end
         end
         StMul: begin
            state_d     = StIdle;
            out_valid_d = 1'b1;
            hilo_we_d   = 1'b1;
            result_d    = '0;
            hi_d        = prod[63:32];
            lo_d        = prod[31:0];
         end
         StDiv: begin
            opa_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d     = StIdle;
               out_valid_d = 1'b1;
               hilo_we_d   = 1'b1;
               result_d    = '0;
               lo_d        = dbz_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_step : quo_step);
               hi_d        = dbz_q ? orig_q : (rneg_q ? -rem_step : rem_step);
            end
         end
         default: state_d = StIdle;
      endcase
      // Flush beats any accept or completion in the same cycle.
      if (bus.flush) begin
         state_d     = StIdle;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         overflow_d  = 1'b0;
         hilo_we_d   = 1'b0;
         result_d    = result_q;
         hi_d        = hi_q;
         lo_d        = lo_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         rem_q       <= '0;
         orig_q      <= '0;
         sgn_q       <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         hilo_we_q   <= 1'b0;
         result_q    <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         rem_q       <= rem_d;
         orig_q      <= orig_d;
         sgn_q       <= sgn_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         hilo_we_q   <= hilo_we_d;
         result_q    <= result_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.overflow  = overflow_q;
   assign bus.hilo_we   = hilo_we_q;
   assign bus.result    = result_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed scenarios plus random ops checked
// against an arithmetic reference model, with a separate output monitor.
module tb_alu_exec;

   logic clk;
   logic resetn;
   alu_exec_if bus ();

   alu_exec dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] result;
      logic        overflow;
      logic        hilo_we;
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model; due holds the extra cycles beyond the single-cycle case.
   function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sa);
      exp_t        e;
      longint      sa64, sb64, s;
      logic [63:0] p;
      e.result = '0; e.overflow = 1'b0; e.hilo_we = 1'b0;
      e.hi = m_hi; e.lo = m_lo; e.due = 0;
      sa64 = longint'($signed(a));
      sb64 = longint'($signed(b));
      case (op)
         5'd1:  e.result = a & b;
         5'd2:  e.result = a | b;
         5'd3:  e.result = a ^ b;
         5'd4:  e.result = ~(a | b);
         5'd5, 5'd7: begin
            s = (op == 5'd5) ? sa64 + sb64 : sa64 - sb64;
            e.result   = s[31:0];
            e.overflow = (s != longint'($signed(s[31:0])));
         end
         5'd6:  e.result = a + b;
         5'd8:  e.result = a - b;
         5'd9:  e.result = (sa64 < sb64) ? 32'd1 : 32'd0;
         5'd10: e.result = (a < b) ? 32'd1 : 32'd0;
         5'd11: e.result = b << sa;
         5'd12: e.result = b * 32'd65536;
         5'd13, 5'd14: begin
            p = (op == 5'd13) ? 64'(sa64 * sb64) : {32'b0, a} * {32'b0, b};
            e.hi = p[63:32]; e.lo = p[31:0]; e.hilo_we = 1'b1; e.due = 1;
         end
         5'd15, 5'd16: begin
            e.hilo_we = 1'b1; e.due = 32;
            if (b == 32'd0) begin
               e.lo = 32'hFFFF_FFFF; e.hi = a;
            end else if (op == 5'd15) begin
               s = sa64 / sb64; e.lo = s[31:0];
               s = sa64 % sb64; e.hi = s[31:0];
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
         default: ;
      endcase
      m_hi = e.hi;
      m_lo = e.lo;
      return e;
   endfunction

   // Monitor: every out_valid pops one expectation and checks fields and timing.
   always @(negedge clk) begin
      if (resetn && bus.out_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("out_cycle", 64'(cyc), 64'(e.due));
            check("result", 64'(bus.result), 64'(e.result));
            check("overflow", 64'(bus.overflow), 64'(e.overflow));
            check("hilo_we", 64'(bus.hilo_we), 64'(e.hilo_we));
            check("hi", 64'(bus.hi), 64'(e.hi));
            check("lo", 64'(bus.lo), 64'(e.lo));
         end
      end
   end

   // Presents one op until accepted; leaves in_valid high so callers can chain.
   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sa, input bit expect_out);
      int   guard = 0;
      exp_t e;
      while (!bus.in_ready) begin
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
         guard++;
         if (guard > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
            return;
         end
      end
      bus.in_valid   = 1'b1;
      bus.alucontrol = op;
      bus.a          = a;
      bus.b          = b;
      bus.sa         = sa;
      if (expect_out) begin
         e     = model(op, a, b, sa);
         e.due = cyc + 1 + e.due;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic count_busy(input string name, input int exp);
      int n = 0;
      bus.in_valid = 1'b0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(n), 64'(exp));
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int guard;
      resetn         = 1'b1;
      bus.flush      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.alucontrol = '0;
      bus.a          = '0;
      bus.b          = '0;
      bus.sa         = '0;
      #2 resetn = 1'b0;
      #1;
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_result", 64'(bus.result), 64'd0);
      check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      send(5'd5, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
      send(5'd6, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
      idle(2);

      check("b2b_ready0", 64'(bus.in_ready), 64'd1);
      send(5'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
      check("b2b_ready1", 64'(bus.in_ready), 64'd1);
      send(5'd10, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
      check("b2b_ready2", 64'(bus.in_ready), 64'd1);
      send(5'd11, 32'h0, 32'd1, 5'd31, 1'b1);
      check("b2b_ready3", 64'(bus.in_ready), 64'd1);
      send(5'd12, 32'h0, 32'h0000_1234, 5'd0, 1'b1);
      idle(2);

      send(5'd13, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
      count_busy("mult_busy_cycles", 1);
      idle(2);
      send(5'd15, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
      count_busy("div_busy_cycles", 32);
      idle(2);
      send(5'd16, 32'd5, 32'd0, 5'd0, 1'b1);
      send(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
      idle(40);

      // Abort a divide mid-flight with a competing op presented.
      send(5'd16, 32'd1000, 32'd7, 5'd0, 1'b0);
      idle(9);
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.alucontrol = 5'd6;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      check("flush_no_valid", 64'(bus.out_valid), 64'd0);
      idle(3);
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_wins_accept", 64'(bus.out_valid), 64'd0);
      idle(40);

      send(5'd16, 32'd100, 32'd7, 5'd0, 1'b0);
      idle(4);
      resetn = 1'b0;
      #1;
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
      check("rst_mid_result", 64'(bus.result), 64'd0);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      idle(1);
      send(5'd15, 32'd100, 32'hFFFF_FFF9, 5'd0, 1'b1);
      idle(40);

      for (int i = 0; i < 150; i++) begin
         logic [4:0] op;
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                          : 5'($urandom_range(0, 16));
         send(op, rnd_val(), rnd_val(), 5'($urandom_range(0, 31)), 1'b1);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      bus.in_valid = 1'b0;

      guard = 0;
      while (sb_q.size() != 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_pending", 64'(sb_q.size()), 64'd0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the MIPS pipeline and the consumer of the 5-bit `alucontrol` code produced by the ALU-control decoder. Single-cycle logic/arithmetic/shift ops complete with one-cycle registered latency. MULT/MULTU and DIV/DIVU run as multi-cycle operations that write HI/LO and stall the issuing stage through a valid/ready handshake.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of any accepted or in-flight operation.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: block can accept an operation; `in_valid & in_ready` at a rising edge means accept.
- `alucontrol` input 5: operation code, encodings below.
- `a` input 32: rs operand / dividend / multiplicand.
- `b` input 32: rt or immediate operand / divisor / multiplier.
- `sa` input 5: shift amount for SLL.
- `out_valid` output 1: one-cycle pulse; result fields are valid.
- `result` output 32: GPR result.
- `overflow` output 1: signed-overflow exception flag for ADD/SUB, qualified by `out_valid`.
- `hilo_we` output 1: HI/LO write enable, qualified by `out_valid`.
- `hi` output 32: high word / remainder.
- `lo` output 32: low word / quotient.

## Operation
- Encodings (fixed in defines.h):
  - NOP 00000, AND 00001, OR 00010, XOR 00011, NOR 00100
  - ADD 00101, ADDU 00110, SUB 00111, SUBU 01000
  - SLT 01001, SLTU 01010, SLL 01011, LUI 01100
  - MULT 01101, MULTU 01110, DIV 01111, DIVU 10000
  - Any other code behaves as NOP: result 0, no overflow, no HI/LO write.
- Single-cycle ops:
  - SLL: `b << sa`.
  - LUI: `{b[15:0],16'h0}`.
  - SLT/SLTU: result is 0 or 1, signed or unsigned compare.
  - ADD/SUB: `overflow` = operand signs agree and result sign differs (for SUB, compare against inverted b).
  - ADDU/SUBU: never flag overflow. The result is produced even when `overflow`=1; suppressing the writeback belongs to the exception logic.
- MULT/MULTU: 64-bit product is signed or unsigned; `{hi,lo}` = product; `result` = 0.
- DIV/DIVU: radix-2 restoring divider, 32 iterations on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). `lo` = quotient, `hi` = remainder.
  - Divide by zero: `lo`=32'hFFFFFFFF, `hi`=a, no exception.
  - 32'h80000000 / -1 (DIV): `lo`=32'h80000000, `hi`=0.
- FSM states:
  - IDLE: `in_ready`=1. Accepting a single-cycle op stays in IDLE. Accepting MULT/MULTU goes to MUL. Accepting DIV/DIVU latches operands, clears counter, goes to DIV.
  - MUL: one cycle; registers the product, then goes to IDLE with `out_valid`.
  - DIV: one iteration per cycle, 5-bit counter 0..31. At count 31 it goes to IDLE with `out_valid`, after sign fix-up.
- `in_ready` is combinational: `(state==IDLE)`.
- `flush` overrides everything:
  - Next state is IDLE and the counter clears.
  - `out_valid`, `hilo_we` and `overflow` are 0 in the following cycle.
  - `flush` together with `in_valid` in the same cycle: flush wins and nothing is accepted.

## Timing
- Reset (`resetn`=0, asynchronous):
  - State IDLE, counter 0.
  - `out_valid`, `hilo_we`, `overflow` = 0; `result`, `hi`, `lo` = 0.
  - `in_ready`=1 while in reset.
- Reset asserted mid-divide discards the operation; the first accept after release starts clean.
- Latency, counted as cycles from the accept edge to the edge where `out_valid` is first seen:
  - Single-cycle op: 1. Throughput is 1 per cycle, so back-to-back accepts give back-to-back `out_valid`.
  - MULT/MULTU: 2.
  - DIV/DIVU: 33.
- `in_ready` returns to 1 in the same cycle `out_valid` pulses, so a new op can be accepted in that cycle.
- `result`/`hi`/`lo` hold their last values when `out_valid`=0. Only the qualifiers pulse.
- There is no output backpressure; the consumer must take results on the `out_valid` cycle.

## Test plan
- Reset, then ADD with a=32'h7FFFFFFF, b=1. Next cycle: `out_valid`=1, `result`=32'h80000000, `overflow`=1. ADDU with the same operands gives `overflow`=0.
- Back-to-back accepts of SLT(a=-1, b=1), SLTU(a=-1, b=1), SLL(b=1, sa=31), LUI(b=16'h1234) on consecutive cycles:
  - results are 1, 0, 32'h80000000, 32'h12340000 on four consecutive cycles;
  - `in_ready` stays 1 throughout.
- MULT a=-2, b=3:
  - `in_ready`=0 for one cycle;
  - `out_valid` at accept+2 with `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFFA, `hilo_we`=1.
- DIV a=-7, b=2:
  - `in_ready` low for 32 cycles;
  - at accept+33: `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
- DIVU a=5, b=0 gives `lo`=32'hFFFFFFFF, `hi`=5. DIV 32'h80000000 / -1 gives `lo`=32'h80000000, `hi`=0.
- Start DIVU and assert `flush` at accept+10 while `in_valid`=1:
  - no `out_valid` for the aborted op;
  - `in_ready`=1 next cycle and nothing is accepted in the flush cycle.

  Then start DIVU again and pull `resetn` low at accept+5: all outputs clear immediately and no `out_valid` occurs for that op.
